// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage.
// Generates the delay-line FIFO strobes and the data-path selects. The FIFO is
// external and is not reset, so stale entries are purged in SYNC after reset.
module sdf_stage_ctrl #(
  parameter int M_WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  output logic o_ready,
  input  logic i_flush,
  input  logic i_fifo_full,
  input  logic i_fifo_empty,
  output logic o_fifo_rd,
  output logic o_fifo_wr,
  output logic o_wr_sel,
  output logic o_out_sel,
  output logic o_valid,
  output logic o_first,
  output logic o_err
);

  // Counter value of the M-th sample of a half-frame (M-1).
  localparam logic [M_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    IDLE  = 3'd1,
    FILL  = 3'd2,
    BFLY  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [M_WIDTH-1:0]   cnt, cnt_n;
  logic                 pend, pend_n;
  logic                 accept;
  logic                 flush_go;
  logic                 wr_n, wr_sel_n, out_sel_n, valid_n, first_n, err_n;

  // Next-state, handshake, read strobe and next values of the registered outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_n   = state;
    cnt_n     = cnt;
    pend_n    = pend;
    o_fifo_rd = 1'b0;
    wr_n      = 1'b0;
    wr_sel_n  = 1'b0;
    out_sel_n = 1'b0;
    valid_n   = 1'b0;
    first_n   = 1'b0;

    // A flush is only honoured at a frame boundary with differences still queued;
    // it wins over a simultaneous sample, which is then refused.
    flush_go = (state == FILL) && (cnt == '0) && pend && i_flush;
    o_ready  = ((state == IDLE) || (state == FILL) || (state == BFLY)) && !flush_go;
    accept   = i_valid && o_ready;

    case (state)
      SYNC: begin
        o_fifo_rd = !i_fifo_empty;
        if (i_fifo_empty) state_n = IDLE;
      end
      IDLE: begin
        if (accept) begin
          wr_n    = 1'b1;
          cnt_n   = cnt + 1'b1;
          state_n = FILL;
        end
      end
      FILL: begin
        if (flush_go) begin
          state_n = FLUSH;
        end else if (accept) begin
          wr_n  = 1'b1;
          cnt_n = cnt + 1'b1;
          // Previous frame's differences leave 1:1 with this frame's fill writes.
          if (pend) begin
            o_fifo_rd = 1'b1;
            valid_n   = 1'b1;
            out_sel_n = 1'b1;
          end
          if (cnt == CNT_LAST) begin
            state_n = BFLY;
            pend_n  = 1'b0;
          end
        end
      end
      BFLY: begin
        if (accept) begin
          o_fifo_rd = 1'b1;
          wr_n      = 1'b1;
          wr_sel_n  = 1'b1;
          valid_n   = 1'b1;
          first_n   = (cnt == '0);
          cnt_n     = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_n = FILL;
            pend_n  = 1'b1;
          end
        end
      end
      FLUSH: begin
        o_fifo_rd = 1'b1;
        valid_n   = 1'b1;
        out_sel_n = 1'b1;
        cnt_n     = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_n = IDLE;
          pend_n  = 1'b0;
        end
      end
      default: begin
        state_n = SYNC;
        cnt_n   = '0;
        pend_n  = 1'b0;
      end
    endcase

    // No FIFO pops while reset is held; SYNC purges only after release.
    if (i_rst) o_fifo_rd = 1'b0;

    err_n = o_err
          | (i_valid && !o_ready)
          | (o_fifo_rd && i_fifo_empty)
          | (o_fifo_wr && i_fifo_full);
  end

  // Control state: FSM state, sample counter and pending-differences flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state <= SYNC;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
    end
  end

  // Registered strobes and selects, one-cycle pulses per event; sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fifo_wr <= 1'b0;
      o_wr_sel  <= 1'b0;
      o_out_sel <= 1'b0;
      o_valid   <= 1'b0;
      o_first   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_fifo_wr <= wr_n;
      o_wr_sel  <= wr_sel_n;
      o_out_sel <= out_sel_n;
      o_valid   <= valid_n;
      o_first   <= first_n;
      o_err     <= err_n;
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl with M_WIDTH=2 (M=4).
// The bench owns a FIFO model and a butterfly data path driven by the DUT's
// strobes; the resulting output stream is compared against frame-level
// expectations (sums x[i]+x[i+4], then differences x[i]-x[i+4]).
module tb_sdf_stage_ctrl;

  localparam int MW = 2;
  localparam int M  = 4;

  typedef int frame_t [8];
  typedef struct {
    int data;
    bit sel;
    bit first;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, o_ready, i_flush;
  logic i_fifo_full, i_fifo_empty;
  logic o_fifo_rd, o_fifo_wr, o_wr_sel, o_out_sel, o_valid, o_first, o_err;

  int   sample_data;
  int   checks   = 0;
  int   failures = 0;

  // Bench-side model state.
  int   q[$];
  exp_t exp_q[$];
  int   occ = 0;
  int   x_d = 0;
  int   rd_d = 0;
  int   max_occ = 0;
  int   valid_cnt = 0;

  sdf_stage_ctrl #(.M_WIDTH(MW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .i_fifo_full  (i_fifo_full),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd    (o_fifo_rd),
    .o_fifo_wr    (o_fifo_wr),
    .o_wr_sel     (o_wr_sel),
    .o_out_sel    (o_out_sel),
    .o_valid      (o_valid),
    .o_first      (o_first),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  // FIFO flags follow the modelled occupancy as of the last clock edge.
  always @(posedge clk) occ <= q.size();
  assign i_fifo_empty = (occ == 0);
  assign i_fifo_full  = (occ == M);

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event observed, none expected (t=%0t)", name, $time);
  endtask

  // Compare process: runs the data path on the DUT's strobes and checks each output.
  always @(negedge clk) begin
    int   out_v;
    int   wr_v;
    int   rd_v;
    bit   got_rd;
    exp_t e;
    if (!rst) begin
      got_rd = 1'b0;
      rd_v   = 0;
      if (o_valid) begin
        valid_cnt++;
        out_v = o_out_sel ? rd_d : rd_d + x_d;
        if (exp_q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_v, e.data);
          check("out_sel", int'(o_out_sel), int'(e.sel));
          check("out_first", int'(o_first), int'(e.first));
        end
      end
      wr_v = o_wr_sel ? rd_d - x_d : x_d;
      if (o_fifo_wr && q.size() >= M) fail("write_while_full");
      if (o_fifo_rd) begin
        if (q.size() == 0) fail("read_while_empty");
        else begin
          rd_v   = q.pop_front();
          got_rd = 1'b1;
        end
      end
      if (o_fifo_wr) q.push_back(wr_v);
      if (q.size() > max_occ) max_occ = q.size();
      if (got_rd) rd_d = rd_v;
      if (i_valid && o_ready) x_d = sample_data;
    end
  end

  task automatic push_sums(input frame_t f);
    for (int i = 0; i < M; i++) exp_q.push_back('{f[i] + f[i+M], 1'b0, (i == 0)});
  endtask

  task automatic push_diffs(input frame_t f);
    for (int i = 0; i < M; i++) exp_q.push_back('{f[i] - f[i+M], 1'b1, 1'b0});
  endtask

  // Drive one sample after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send_sample(input int v, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    i_valid     = 1'b1;
    sample_data = v;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int n);
    for (int i = 0; i < n; i++) send_sample(f[i], 0);
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (o_ready) seen = 1'b1;
    end
    if (!seen) fail("ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic end_of_test(input string name);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_occupancy"}, q.size(), 0);
    check({name, "_err"}, int'(o_err), 0);
    check({name, "_ready"}, int'(o_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t fx, fa, fb, fc, fd;
    int     gaps [8];
    int     rd_n;
    bit     done;
    logic [5:0] vpat;

    fx   = '{3, 7, 1, 9, 20, 4, 15, 2};
    gaps = '{0, 2, 1, 3, 0, 1, 2, 0};
    for (int i = 0; i < 8; i++) begin
      fa[i] = 100 + 7 * i;
      fb[i] = 5 * i * i - 30;
      fc[i] = 11 * i + 1;
      fd[i] = 40 - 3 * i;
    end

    rst = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    sample_data = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", int'(o_valid), 0);
    check("rst_fifo_wr", int'(o_fifo_wr), 0);
    check("rst_first", int'(o_first), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_ready", int'(o_ready), 0);
    check("rst_fifo_rd", int'(o_fifo_rd), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(20);

    // Single frame, hand-computed sums and differences, then flush.
    exp_q.push_back('{23, 1'b0, 1'b1});
    exp_q.push_back('{11, 1'b0, 1'b0});
    exp_q.push_back('{16, 1'b0, 1'b0});
    exp_q.push_back('{11, 1'b0, 1'b0});
    exp_q.push_back('{-17, 1'b1, 1'b0});
    exp_q.push_back('{3, 1'b1, 1'b0});
    exp_q.push_back('{-14, 1'b1, 1'b0});
    exp_q.push_back('{7, 1'b1, 1'b0});
    send_frame(fx, 8);
    pulse_flush();
    vpat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vpat = {vpat[4:0], o_valid};
    end
    check("flush_valid_pattern", int'(vpat), int'(6'b011110));
    idle(4);
    end_of_test("t1");

    // Two back-to-back frames: drain of frame A interleaves with fill of frame B.
    max_occ = 0;
    push_sums(fa);
    push_diffs(fa);
    push_sums(fb);
    push_diffs(fb);
    send_frame(fa, 8);
    send_frame(fb, 8);
    pulse_flush();
    idle(10);
    check("t2_max_occupancy", max_occ, M);
    end_of_test("t2");

    // Reset after three butterfly samples leaves four stale entries to purge.
    push_sums(fc);
    void'(exp_q.pop_back());
    send_frame(fc, 7);
    idle(3);
    check("t3_exp_left", exp_q.size(), 0);
    check("t3_stale_entries", q.size(), M);
    rst = 1'b1;
    @(negedge clk);
    check("t3_rst_valid", int'(o_valid), 0);
    check("t3_rst_fifo_rd", int'(o_fifo_rd), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (o_ready) done = 1'b1;
      else if (o_fifo_rd) rd_n++;
    end
    check("t3_sync_reached_idle", int'(done), 1);
    check("t3_sync_reads", rd_n, M);
    @(posedge clk);
    #1;
    end_of_test("t3");

    // Same frame as the first test, with stalls between samples.
    exp_q.push_back('{23, 1'b0, 1'b1});
    exp_q.push_back('{11, 1'b0, 1'b0});
    exp_q.push_back('{16, 1'b0, 1'b0});
    exp_q.push_back('{11, 1'b0, 1'b0});
    valid_cnt = 0;
    for (int i = 0; i < 8; i++) send_sample(fx[i], gaps[i]);
    idle(2);
    check("t4_valid_count", valid_cnt, M);
    push_diffs(fx);
    pulse_flush();
    idle(8);
    end_of_test("t4");

    // A sample offered during FLUSH is dropped and raises a sticky error.
    push_sums(fd);
    push_diffs(fd);
    send_frame(fd, 8);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b1;
    sample_data = 999;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    idle(8);
    check("t5_err_set", int'(o_err), 1);
    check("t5_exp_left", exp_q.size(), 0);
    check("t5_sample_dropped", q.size(), 0);
    check("t5_ready", int'(o_ready), 1);
    idle(5);
    check("t5_err_held", int'(o_err), 1);
    rst = 1'b1;
    #1;
    check("t5_err_async_clear", int'(o_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(20);
    check("t5_err_after_reset", int'(o_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter M_WIDTH, default 8, meaning delay-line depth M = 2^M_WIDTH and frame length 2M samples.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1, input sample present this cycle.
REQ-005 SHALL have port o_ready, output, 1, sample accepted when i_valid && o_ready.
REQ-006 SHALL have port i_flush, input, 1, request to drain pending FIFO contents with no new input.
REQ-007 SHALL have ports i_fifo_full and i_fifo_empty, input, 1 each, delay-line FIFO status flags.
REQ-008 SHALL have port o_fifo_rd, output, 1, FIFO read strobe (combinational).
REQ-009 SHALL have port o_fifo_wr, output, 1, FIFO write strobe (registered).
REQ-010 SHALL have port o_wr_sel, output, 1, FIFO write-data select (registered): 0 = delayed input sample, 1 = butterfly difference.
REQ-011 SHALL have port o_out_sel, output, 1, output-data select (registered): 0 = butterfly sum, 1 = FIFO data.
REQ-012 SHALL have port o_valid, output, 1, output sample valid (registered).
REQ-013 SHALL have port o_first, output, 1, marks first output of each frame (registered).
REQ-014 SHALL have port o_err, output, 1, sticky protocol error.

Function
REQ-015 SHALL implement states SYNC, IDLE, FILL, BFLY, FLUSH, with an M_WIDTH-bit sample counter cnt and a pend flag for the previous frame's M differences still in the FIFO.
REQ-016 SYNC: o_ready=0; o_fifo_rd=!i_fifo_empty each cycle to discard stale contents; the first cycle with i_fifo_empty=1 SHALL go to IDLE.
REQ-017 IDLE/FILL: o_ready=1; each accepted sample at cycle t SHALL give o_fifo_wr=1, o_wr_sel=0 at t+1.
REQ-018 FILL with pend=1: each accepted sample SHALL also give o_fifo_rd=1 at t, plus o_valid=1 and o_out_sel=1 at t+1.
REQ-019 FILL drain reads SHALL stop after the M-th read and clear pend; o_first=1 SHALL NOT be raised by drain outputs.
REQ-020 IDLE: first accepted sample SHALL move to FILL with cnt=1; FILL SHALL move to BFLY when the M-th write of the frame is accepted (cnt wraps to 0).
REQ-021 BFLY: accepted sample at t SHALL give o_fifo_rd=1 at t; at t+1, o_fifo_wr=1, o_wr_sel=1, o_valid=1, o_out_sel=0.
REQ-022 o_first SHALL be 1 on the BFLY output of the frame's (M+1)-th sample only.
REQ-023 After the M-th BFLY sample, the block SHALL go to FILL with pend=1 and cnt=0.
REQ-024 FILL with cnt=0, pend=1 and i_flush=1 SHALL go to FLUSH; i_flush SHALL be ignored in every other state/condition.
REQ-025 FLUSH: o_ready=0; o_fifo_rd=1 each cycle for M cycles, giving o_valid=1, o_out_sel=1 one cycle later; it SHALL then go to IDLE with pend=0.
REQ-026 i_valid while o_ready=0 SHALL drop the sample and set o_err.
REQ-027 o_fifo_rd while i_fifo_empty=1, or o_fifo_wr while i_fifo_full=1, SHALL set o_err; the strobe SHALL still be issued.
REQ-028 FIFO occupancy SHALL never exceed M; a concurrent read at t and write at t+1 is legal at occupancy M.
REQ-029 i_valid=0 stalls SHALL freeze cnt, state and pend; a registered output SHALL be 1 for exactly one cycle per event.

Reset
REQ-030 i_rst=1 SHALL immediately force state=SYNC, cnt=0, pend=0, and o_fifo_wr, o_wr_sel, o_out_sel, o_valid, o_first, o_err all 0.
REQ-031 Reset mid-frame SHALL discard that frame; the FIFO is not reset, so stale contents SHALL be purged via SYNC.
REQ-032 o_err SHALL clear only on reset.

Verification
REQ-033 M_WIDTH=2, FIFO empty, reset released, continuous samples x0..x7 -> writes of x0..x3 (sel 0), then BFLY outputs x0+x4..x3+x7 with o_first on the first, and diffs written.
REQ-034 Same frame, then i_flush at cnt=0 -> 4 consecutive outputs x0-x4..x3-x7 (out_sel 1), then IDLE, FIFO empty, o_err=0.
REQ-035 Two back-to-back frames -> frame-1 diffs interleaved 1:1 with frame-2 fill writes; FIFO occupancy stays 4; no full/empty error.
REQ-036 Reset asserted after 3 BFLY samples with 4 entries stale -> SYNC issues 4 reads, o_ready=0 for those cycles, then IDLE.
REQ-037 i_valid pulses with random gaps -> identical output sequence to REQ-033, with one o_valid per accepted BFLY sample.
REQ-038 i_valid during FLUSH -> sample dropped, o_err=1 and held until reset.
